// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory slave data path: default word width,
// the word type and the bit-counter width helper.
package spi_pkg;

    localparam int SPI_WORD_W = 8;

    typedef logic [SPI_WORD_W-1:0] spi_word_t;

    // Wide enough to hold the values 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/spi_shift_register_if.sv
// Control and data bundle of the SPI shift register.
// Counter outputs exist only when SHIFTREG_BITCNT_EN is defined.
interface spi_shift_register_if
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WORD_W
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic             peripheralClkEdge;
    logic             parallelLoad;
    logic [WIDTH-1:0] parallelDataIn;
    logic             serialDataIn;
    logic [WIDTH-1:0] parallelDataOut;
    logic             serialDataOut;
`ifdef SHIFTREG_BITCNT_EN
    logic [CNT_W-1:0] bitCount;
    logic             wordDone;
`endif

    modport master (
        output peripheralClkEdge,
        output parallelLoad,
        output parallelDataIn,
        output serialDataIn,
        input  parallelDataOut,
        input  serialDataOut
`ifdef SHIFTREG_BITCNT_EN
        ,
        input  bitCount,
        input  wordDone
`endif
    );

    modport slave (
        input  peripheralClkEdge,
        input  parallelLoad,
        input  parallelDataIn,
        input  serialDataIn,
        output parallelDataOut,
        output serialDataOut
`ifdef SHIFTREG_BITCNT_EN
        ,
        output bitCount,
        output wordDone
`endif
    );

endinterface

// File: rtl/spi_bit_counter.sv
// Counts shifts within a word and pulses word_done for one clk after the
// WIDTH-th shift; a parallel load clears the count and suppresses the pulse.
module spi_bit_counter
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WORD_W,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    output logic [CNT_W-1:0] bit_count,
    output logic             word_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_count <= '0;
            word_done <= 1'b0;
        end else if (load) begin
            bit_count <= '0;
            word_done <= 1'b0;
        end else if (shift) begin
            if (bit_count == LAST) begin
                bit_count <= '0;
                word_done <= 1'b1;
            end else begin
                bit_count <= bit_count + 1'b1;
                word_done <= 1'b0;
            end
        end else begin
            word_done <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_shift_register.sv
// PIPO/SISO shift register forming the SPI slave data path; shifts MSB-first.
// Optional shift counter enabled by defining SHIFTREG_BITCNT_EN.
module spi_shift_register
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WORD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_shift_register_if.slave  bus
);

    logic [WIDTH-1:0] shreg;

    // Load takes priority over a coincident shift edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (bus.parallelLoad) begin
            shreg <= bus.parallelDataIn;
        end else if (bus.peripheralClkEdge) begin
            shreg <= {shreg[WIDTH-2:0], bus.serialDataIn};
        end
    end

    assign bus.parallelDataOut = shreg;
    assign bus.serialDataOut   = shreg[WIDTH-1];

`ifdef SHIFTREG_BITCNT_EN
    spi_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (bus.parallelLoad),
        .shift     (bus.peripheralClkEdge),
        .bit_count (bus.bitCount),
        .word_done (bus.wordDone)
    );
`endif

endmodule

// File: tb/tb_spi_shift_register.sv
// Directed self-checking bench for spi_shift_register (8-bit default width).
// Counter checks are compiled in when SHIFTREG_BITCNT_EN is defined.
module tb_spi_shift_register;
    import spi_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    spi_shift_register_if #(.WIDTH(SPI_WORD_W)) bus ();

    spi_shift_register #(.WIDTH(SPI_WORD_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic load, input logic edge_en,
                                  input spi_word_t data, input logic sin);
        bus.parallelLoad      = load;
        bus.peripheralClkEdge = edge_en;
        bus.parallelDataIn    = data;
        bus.serialDataIn      = sin;
    endtask

    initial begin
        spi_word_t bits_in;
        spi_word_t bits_out;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);

        // Power-on reset
        #12;
        check_output("reset_pdo", 32'(bus.parallelDataOut), 32'h00);
        check_output("reset_sdo", 32'(bus.serialDataOut), 32'h0);
`ifdef SHIFTREG_BITCNT_EN
        check_output("reset_cnt", 32'(bus.bitCount), 32'h0);
        check_output("reset_done", 32'(bus.wordDone), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-cycle after loading all ones
        apply_stimulus(1'b1, 1'b0, 8'hFF, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("load_ff", 32'(bus.parallelDataOut), 32'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_pdo", 32'(bus.parallelDataOut), 32'h00);
        check_output("async_rst_sdo", 32'(bus.serialDataOut), 32'h0);
        #1;
        rst_n = 1'b1;

        // Parallel load
        apply_stimulus(1'b1, 1'b0, 8'hA5, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("load_a5_pdo", 32'(bus.parallelDataOut), 32'hA5);
        check_output("load_a5_sdo", 32'(bus.serialDataOut), 32'h1);

        // Serial shift-in of 1,0,1,1,0,0,1,0
        bits_in = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b1, 8'h00, bits_in[7-i]);
            tick();
`ifdef SHIFTREG_BITCNT_EN
            if (i == 6) begin
                check_output("cnt_after7", 32'(bus.bitCount), 32'h7);
                check_output("done_after7", 32'(bus.wordDone), 32'h0);
            end
            if (i == 7) begin
                check_output("cnt_after8", 32'(bus.bitCount), 32'h0);
                check_output("done_after8", 32'(bus.wordDone), 32'h1);
            end
`endif
        end
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("shift_in_b2", 32'(bus.parallelDataOut), 32'hB2);
        tick();
        check_output("shift_in_hold", 32'(bus.parallelDataOut), 32'hB2);
`ifdef SHIFTREG_BITCNT_EN
        check_output("done_one_pulse", 32'(bus.wordDone), 32'h0);
`endif

        // Serial shift-out of 8'h5C, MSB first
        apply_stimulus(1'b1, 1'b0, 8'h5C, 1'b0);
        tick();
        bits_out = 8'b0101_1100;
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("shift_out_bit%0d", i), 32'(bus.serialDataOut),
                         32'(bits_out[7-i]));
            apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0);
            tick();
        end
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("shift_out_final", 32'(bus.parallelDataOut), 32'h00);

        // Load beats a coincident shift edge
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        apply_stimulus(1'b1, 1'b1, 8'h3C, 1'b1);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("priority_3c", 32'(bus.parallelDataOut), 32'h3C);
`ifdef SHIFTREG_BITCNT_EN
        check_output("priority_cnt", 32'(bus.bitCount), 32'h0);
`endif

        // Back-to-back shifts from 8'h81 with ones, then hold
        apply_stimulus(1'b1, 1'b0, 8'h81, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b1, 8'h00, 1'b1);
        tick();
        check_output("b2b_shift1", 32'(bus.parallelDataOut), 32'h03);
        tick();
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
        check_output("b2b_shift3", 32'(bus.parallelDataOut), 32'h0F);
`ifdef SHIFTREG_BITCNT_EN
        check_output("b2b_cnt", 32'(bus.bitCount), 32'h3);
`endif
        tick();
        tick();
        check_output("hold_0f", 32'(bus.parallelDataOut), 32'h0F);

`ifdef SHIFTREG_BITCNT_EN
        // A load coinciding with the word-completing shift suppresses wordDone
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(1'b0, 1'b1, 8'h00, 1'b1);
            tick();
        end
        apply_stimulus(1'b1, 1'b1, 8'hC3, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("suppress_pdo", 32'(bus.parallelDataOut), 32'hC3);
        check_output("suppress_done", 32'(bus.wordDone), 32'h0);
        check_output("suppress_cnt", 32'(bus.bitCount), 32'h0);
        tick();
        check_output("suppress_done_next", 32'(bus.wordDone), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
